// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + owning ROB tag).
// Optional REG_BYPASS_EN forwards a same-cycle commit onto the query outputs.
module reg_status_file #(
    parameter int ROB_LOG = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               clear,
    input  logic               commit_enable,
    input  logic [4:0]         commit_index,
    input  logic [ROB_LOG-1:0] commit_RobId,
    input  logic [31:0]        commit_value,
    input  logic               issue_valid,
    input  logic [4:0]         issue_dest,
    input  logic [ROB_LOG-1:0] issue_RobId,
    input  logic [4:0]         query_rs1,
    input  logic [4:0]         query_rs2,
    output logic               rs1_busy,
    output logic [ROB_LOG-1:0] rs1_RobId,
    output logic [31:0]        rs1_value,
    output logic               rs2_busy,
    output logic [ROB_LOG-1:0] rs2_RobId,
    output logic [31:0]        rs2_value
);

    logic [31:0]        value [32];
    logic [31:0]        busy;
    logic [ROB_LOG-1:0] tag   [32];
    logic [31:0]        busy_next;

    logic commit_hit;
    logic issue_hit;

    assign commit_hit = commit_enable && (commit_index != 5'd0);
    assign issue_hit  = issue_valid && (issue_dest != 5'd0) && !clear;

    // Commit releases only when it matches the current owner; issue then overrides; clear drops all.
    always_comb begin
        busy_next = busy;
        if (commit_hit && busy[commit_index] && (tag[commit_index] == commit_RobId))
            busy_next[commit_index] = 1'b0;
        if (issue_hit)
            busy_next[issue_dest] = 1'b1;
        if (clear)
            busy_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            for (int i = 0; i < 32; i++) begin
                value[i] <= '0;
                tag[i]   <= '0;
            end
        end else if (rdy) begin
            busy <= busy_next;
            if (commit_hit)
                value[commit_index] <= commit_value;
            if (issue_hit)
                tag[issue_dest] <= issue_RobId;
        end
    end

`ifdef REG_BYPASS_EN
    logic fwd1;
    logic fwd2;

    assign fwd1 = rdy && commit_hit && (commit_index == query_rs1);
    assign fwd2 = rdy && commit_hit && (commit_index == query_rs2);

    always_comb begin
        rs1_RobId = tag[query_rs1];
        rs2_RobId = tag[query_rs2];
        rs1_value = fwd1 ? commit_value : value[query_rs1];
        rs2_value = fwd2 ? commit_value : value[query_rs2];
        rs1_busy  = busy[query_rs1] && !(fwd1 && (tag[query_rs1] == commit_RobId));
        rs2_busy  = busy[query_rs2] && !(fwd2 && (tag[query_rs2] == commit_RobId));
    end
`else
    always_comb begin
        rs1_RobId = tag[query_rs1];
        rs2_RobId = tag[query_rs2];
        rs1_value = value[query_rs1];
        rs2_value = value[query_rs2];
        rs1_busy  = busy[query_rs1];
        rs2_busy  = busy[query_rs2];
    end
`endif

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file: rename, commit ownership, clear, rdy hold, bypass.
module tb_reg_status_file;

    localparam int ROB_LOG = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               rdy;
    logic               clear;
    logic               commit_enable;
    logic [4:0]         commit_index;
    logic [ROB_LOG-1:0] commit_RobId;
    logic [31:0]        commit_value;
    logic               issue_valid;
    logic [4:0]         issue_dest;
    logic [ROB_LOG-1:0] issue_RobId;
    logic [4:0]         query_rs1;
    logic [4:0]         query_rs2;
    logic               rs1_busy;
    logic [ROB_LOG-1:0] rs1_RobId;
    logic [31:0]        rs1_value;
    logic               rs2_busy;
    logic [ROB_LOG-1:0] rs2_RobId;
    logic [31:0]        rs2_value;

    int n_vec  = 0;
    int n_miss = 0;

    reg_status_file #(.ROB_LOG(ROB_LOG)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .commit_enable(commit_enable), .commit_index(commit_index),
        .commit_RobId(commit_RobId), .commit_value(commit_value),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_RobId(issue_RobId),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .rs1_busy(rs1_busy), .rs1_RobId(rs1_RobId), .rs1_value(rs1_value),
        .rs2_busy(rs2_busy), .rs2_RobId(rs2_RobId), .rs2_value(rs2_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    task automatic idle();
        clear         = 1'b0;
        commit_enable = 1'b0;
        commit_index  = '0;
        commit_RobId  = '0;
        commit_value  = '0;
        issue_valid   = 1'b0;
        issue_dest    = '0;
        issue_RobId   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic do_issue(input logic [4:0] d, input logic [ROB_LOG-1:0] t);
        issue_valid = 1'b1;
        issue_dest  = d;
        issue_RobId = t;
    endtask

    task automatic do_commit(input logic [4:0] d, input logic [ROB_LOG-1:0] t, input logic [31:0] v);
        commit_enable = 1'b1;
        commit_index  = d;
        commit_RobId  = t;
        commit_value  = v;
    endtask

    task automatic look(input logic [4:0] a, input logic [4:0] b);
        query_rs1 = a;
        query_rs2 = b;
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        rdy = 1'b1;
        query_rs1 = 5'd5;
        query_rs2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state.
        look(5'd5, 5'd0);
        check("rst_rs1_busy", 32'(rs1_busy), 32'd0);
        check("rst_rs1_id", 32'(rs1_RobId), 32'd0);
        check("rst_rs1_val", rs1_value, 32'd0);
        check("rst_rs2_busy", 32'(rs2_busy), 32'd0);
        check("rst_rs2_val", rs2_value, 32'd0);

        // Issue to x0 is ignored.
        do_issue(5'd0, 4'd3);
        tick();
        look(5'd0, 5'd0);
        check("x0_busy", 32'(rs1_busy), 32'd0);
        check("x0_val", rs1_value, 32'd0);

        // Basic rename then matching commit.
        do_issue(5'd5, 4'd2);
        tick();
        look(5'd5, 5'd0);
        check("x5_busy", 32'(rs1_busy), 32'd1);
        check("x5_id", 32'(rs1_RobId), 32'd2);
        do_commit(5'd5, 4'd2, 32'hDEADBEEF);
        tick();
        look(5'd0, 5'd5);
        check("x5_rel_busy", 32'(rs2_busy), 32'd0);
        check("x5_rel_val", rs2_value, 32'hDEADBEEF);

        // Older producer commits while a younger one owns x7.
        do_issue(5'd7, 4'd1);
        tick();
        do_issue(5'd7, 4'd4);
        tick();
        do_commit(5'd7, 4'd1, 32'h11);
        tick();
        look(5'd7, 5'd0);
        check("x7_old_busy", 32'(rs1_busy), 32'd1);
        check("x7_old_id", 32'(rs1_RobId), 32'd4);
        check("x7_old_val", rs1_value, 32'h11);
        do_commit(5'd7, 4'd4, 32'h22);
        tick();
        look(5'd7, 5'd0);
        check("x7_new_busy", 32'(rs1_busy), 32'd0);
        check("x7_new_val", rs1_value, 32'h22);

        // Same-cycle commit and issue: issue owns, commit writes value.
        do_commit(5'd9, 4'd5, 32'h33);
        do_issue(5'd9, 4'd6);
        tick();
        look(5'd9, 5'd0);
        check("x9_busy", 32'(rs1_busy), 32'd1);
        check("x9_id", 32'(rs1_RobId), 32'd6);
        check("x9_val", rs1_value, 32'h33);

        // Commit to a non-busy register writes value only.
        do_commit(5'd10, 4'd3, 32'hA5A5_0001);
        tick();
        look(5'd10, 5'd0);
        check("x10_busy", 32'(rs1_busy), 32'd0);
        check("x10_val", rs1_value, 32'hA5A5_0001);

        // Clear with concurrent commit and issue.
        do_issue(5'd1, 4'd2);
        tick();
        do_issue(5'd2, 4'd3);
        tick();
        look(5'd1, 5'd2);
        check("pre_clr_x1", 32'(rs1_busy), 32'd1);
        check("pre_clr_x2", 32'(rs2_busy), 32'd1);
        clear = 1'b1;
        do_commit(5'd1, 4'd7, 32'h44);
        do_issue(5'd3, 4'd8);
        tick();
        look(5'd1, 5'd2);
        check("clr_x1_busy", 32'(rs1_busy), 32'd0);
        check("clr_x1_val", rs1_value, 32'h44);
        check("clr_x2_busy", 32'(rs2_busy), 32'd0);
        look(5'd3, 5'd9);
        check("clr_x3_busy", 32'(rs1_busy), 32'd0);
        check("clr_x9_busy", 32'(rs2_busy), 32'd0);

        // rdy low freezes state.
        rdy = 1'b0;
        do_commit(5'd2, 4'd3, 32'h99);
        do_issue(5'd6, 4'd5);
        tick();
        rdy = 1'b1;
        look(5'd2, 5'd6);
        check("hold_x2_val", rs1_value, 32'd0);
        check("hold_x6_busy", 32'(rs2_busy), 32'd0);

        // Commit-cycle view of a busy register (bypass dependent).
        do_issue(5'd4, 4'd9);
        tick();
        look(5'd4, 5'd0);
        do_commit(5'd4, 4'd9, 32'h55);
        #1;
`ifdef REG_BYPASS_EN
        check("byp_busy", 32'(rs1_busy), 32'd0);
        check("byp_val", rs1_value, 32'h55);
`else
        check("nobyp_busy", 32'(rs1_busy), 32'd1);
        check("nobyp_id", 32'(rs1_RobId), 32'd9);
        check("nobyp_val", rs1_value, 32'd0);
`endif
        tick();
        look(5'd4, 5'd0);
        check("x4_busy", 32'(rs1_busy), 32'd0);
        check("x4_val", rs1_value, 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
